// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a
// matching 2-bit mux select; an owner keeps the grant until it drops req or HOLD_MAX expires.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       hold_hit;
  logic       rel;
  logic       take;

  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = '0;
    // The owner is always last_q, so a lone expired owner is found again at offset 4.
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_q + i[1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    hold_hit = (HOLD_MAX != 0) && (hold_q == HOLD_MAX[7:0]);
    rel      = !req[last_q] || hold_hit;
    take     = 1'b0;
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    last_d   = last_q;
    hold_d   = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (found) take = 1'b1;
      end
      ST_GRANT: begin
        if (!rel) begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end else if (found) begin
          take = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase

    if (take) begin
      state_d = ST_GRANT;
      grant_d = 4'b0001 << winner;
      sel_d   = winner;
      busy_d  = 1'b1;
      last_d  = winner;
      hold_d  = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (HOLD_MAX 8, 4, 0) checked each cycle against
// a behavioural model through an expected-value queue, plus fixed anchor values.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_v [3];
  logic [3:0] req_v [3];
  logic [3:0] gnt   [3];
  logic [1:0] sl    [3];
  logic       bsy   [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.HOLD_MAX(8)) u_h8 (.clk(clk), .rst_n(rst_v[0]), .req(req_v[0]),
                                     .grant(gnt[0]), .sel(sl[0]), .busy(bsy[0]));
  rr_arbiter4 #(.HOLD_MAX(4)) u_h4 (.clk(clk), .rst_n(rst_v[1]), .req(req_v[1]),
                                     .grant(gnt[1]), .sel(sl[1]), .busy(bsy[1]));
  rr_arbiter4 #(.HOLD_MAX(0)) u_h0 (.clk(clk), .rst_n(rst_v[2]), .req(req_v[2]),
                                     .grant(gnt[2]), .sel(sl[2]), .busy(bsy[2]));

  typedef struct {
    bit         on;
    int         own;
    int         last;
    int         hold;
    logic [1:0] sel;
  } mst_t;

  typedef struct {
    int         d;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  mst_t m [3];
  exp_t q [$];
  int   hm [3] = '{8, 4, 0};
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic mst_t mnext(input mst_t s, input logic [3:0] r, input logic rn,
                                 input int lim);
    mst_t n = s;
    int   pick = -1;
    if (!rn) begin
      n.on = 0; n.sel = 2'b00; n.last = 3; n.hold = 0;
      return n;
    end
    for (int k = 1; k <= 4; k++)
      if (pick < 0 && r[(s.last + k) % 4]) pick = (s.last + k) % 4;
    if (s.on && r[s.own] && !(lim != 0 && s.hold == lim)) begin
      n.hold = (s.hold < 255) ? s.hold + 1 : 255;
      return n;
    end
    if (pick >= 0) begin
      n.on = 1; n.own = pick; n.last = pick; n.sel = 2'(pick); n.hold = 1;
    end else begin
      n.on = 0; n.hold = 0;
    end
    return n;
  endfunction

  task automatic tick();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      m[d] = mnext(m[d], req_v[d], rst_v[d], hm[d]);
      e.d = d;
      e.g = m[d].on ? (4'b0001 << m[d].own) : 4'b0000;
      e.s = m[d].sel;
      e.b = m[d].on;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("c%0d_d%0d_gsb", cyc, e.d), {25'd0, gnt[e.d], sl[e.d], bsy[e.d]},
            {25'd0, e.g, e.s, e.b});
    end
  endtask

  task automatic reset_one(input int d);
    rst_v[d] = 1'b0;
    tick();
    rst_v[d] = 1'b1;
  endtask

  logic [3:0] order [$];
  logic [3:0] prev;
  int         tg [4];
  logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b0;
      req_v[d] = 4'b0000;
      m[d] = '{on: 0, own: 0, last: 3, hold: 0, sel: 2'b00};
    end
    #1;
    tick();
    tick();
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) tick();
    check("idle_grant", {28'd0, gnt[0]}, 32'h0);
    check("idle_sel", {30'd0, sl[0]}, 32'h0);
    check("idle_busy", {31'd0, bsy[0]}, 32'h0);

    // 2: two requesters, hold limit 8
    reset_one(0);
    req_v[0] = 4'b0101;
    tick();
    check("h8_first", {26'd0, gnt[0], sl[0]}, {26'd0, 4'b0001, 2'b00});
    for (int i = 0; i < 7; i++) tick();
    check("h8_hold8", {28'd0, gnt[0]}, 32'h1);
    tick();
    check("h8_handoff", {26'd0, gnt[0], sl[0]}, {26'd0, 4'b0100, 2'b10});
    for (int i = 0; i < 7; i++) tick();
    check("h8_m2_hold", {28'd0, gnt[0]}, 32'h4);
    tick();
    check("h8_back_to_0", {27'd0, gnt[0], bsy[0]}, {27'd0, 4'b0001, 1'b1});
    for (int i = 0; i < 10; i++) tick();

    // 3: fairness with short drops
    reset_one(0);
    req_v[0] = 4'b1111;
    for (int i = 0; i < 4; i++) tg[i] = -10;
    prev = 4'b0000;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (gnt[0] != prev && gnt[0] != 4'b0000) order.push_back(gnt[0]);
      prev = gnt[0];
      if (m[0].on && m[0].hold == 1) tg[m[0].own] = cyc;
      for (int k = 0; k < 4; k++) req_v[0][k] = (cyc != tg[k] + 2);
      check($sformatf("rr_busy_%0d", i), {31'd0, bsy[0]}, 32'h1);
    end
    check("rr_order_len", {31'd0, order.size() >= 5}, 32'h1);
    for (int k = 0; k < 5 && k < order.size(); k++)
      check($sformatf("rr_order_%0d", k), {28'd0, order[k]}, {28'd0, exp_order[k]});

    // 4: single requester, hold limit 4
    req_v[0] = 4'b0000;
    req_v[1] = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("h4_solo_%0d", i), {27'd0, gnt[1], bsy[1]}, {27'd0, 4'b0010, 1'b1});
    end
    req_v[1] = 4'b0000;
    tick();
    check("h4_drop", {25'd0, gnt[1], sl[1], bsy[1]}, {25'd0, 4'b0000, 2'b01, 1'b0});

    // 5: unlimited hold
    req_v[2] = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("h0_hold_%0d", i), {28'd0, gnt[2]}, 32'h1);
    end
    req_v[2] = 4'b0010;
    tick();
    check("h0_handoff", {26'd0, gnt[2], sl[2]}, {26'd0, 4'b0010, 2'b01});

    // 6: reset mid-grant
    reset_one(0);
    req_v[0] = 4'b0100;
    tick();
    check("rst_pre", {28'd0, gnt[0]}, 32'h4);
    reset_one(0);
    check("rst_mid", {25'd0, gnt[0], sl[0], bsy[0]}, 32'h0);
    req_v[0] = 4'b1100;
    tick();
    check("rst_after", {26'd0, gnt[0], sl[0]}, {26'd0, 4'b0100, 2'b10});

    // random traffic on all instances, with occasional resets
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 3; d++) begin
        req_v[d] = 4'($urandom_range(0, 15));
        rst_v[d] = ($urandom_range(0, 40) != 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
